// File: rtl/pipeline_sched_pkg.sv
// rtl/pipeline_sched_pkg.sv - shared FSM encoding and default sizes for pipeline_sched
package pipeline_sched_pkg;

  localparam int N_CORE_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_sched_core_slot.sv
// rtl/pipeline_sched_core_slot.sv - per-core busy flag and sticky completion-protocol error
module core_slot (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_end,
  output logic o_busy,
  output logic o_err
);

  logic r_busy;
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      // An issue only targets an idle core, so start and a valid end never collide
      if (i_start)
        r_busy <= 1'b1;
      else if (i_end)
        r_busy <= 1'b0;
      if (i_end && !r_busy)
        r_err <= 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_err  = r_err;

endmodule

// File: rtl/pipeline_sched.sv
// rtl/pipeline_sched.sv - round-robin tile issue scheduler across N_CORE compute cores
module pipeline_sched
  import pipeline_sched_pkg::*;
#(
  parameter int N_CORE = N_CORE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              init_signal,
  input  logic [CNT_W-1:0]  num_tiles,
  input  logic              activate_ready,
  input  logic              weight_ready,
  input  logic [N_CORE-1:0] core_end,
  output logic [N_CORE-1:0] start_core,
  output logic              start_load,
  output logic [N_CORE-1:0] core_busy,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic              err
);

  localparam int PTR_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_issued;
  logic [N_CORE-1:0] r_start_core;
  logic              r_start_load;
  logic              r_busy;
  logic              r_done;

  logic              w_issue;
  logic [N_CORE-1:0] w_issue_vec;
  logic [N_CORE-1:0] w_slot_err;
  logic [CNT_W-1:0]  w_issued_nxt;
  logic [PTR_W-1:0]  w_ptr_nxt;

  // A busy core at the pointer stalls the job; it is never skipped
  assign w_issue      = (r_state == ST_RUN) && en && activate_ready && weight_ready &&
                        !core_busy[r_ptr] && (r_issued < r_num);
  assign w_issue_vec  = N_CORE'(w_issue) << r_ptr;
  assign w_issued_nxt = r_issued + CNT_W'(1);
  assign w_ptr_nxt    = (r_ptr == PTR_W'(N_CORE - 1)) ? '0 : r_ptr + PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_num        <= '0;
      r_issued     <= '0;
      r_start_core <= '0;
      r_start_load <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_start_core <= w_issue_vec;
      r_start_load <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (init_signal) begin
            if (num_tiles != '0) begin
              r_num        <= num_tiles;
              r_issued     <= '0;
              r_ptr        <= '0;
              r_start_load <= 1'b1;
              r_busy       <= 1'b1;
              r_state      <= ST_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_issued     <= w_issued_nxt;
            r_ptr        <= w_ptr_nxt;
            // Prefetch the next activation unless this was the job's last tile
            r_start_load <= (w_issued_nxt != r_num);
            r_state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_state <= (r_issued == r_num) ? ST_DRAIN : ST_RUN;
        end
        ST_DRAIN: begin
          if (core_busy == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CORE; k++) begin : g_slot
    core_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_issue_vec[k]),
      .i_end   (core_end[k]),
      .o_busy  (core_busy[k]),
      .o_err   (w_slot_err[k])
    );
  end

  assign start_core = r_start_core;
  assign start_load = r_start_load;
  assign busy       = r_busy;
  assign done       = r_done;
  assign issued_cnt = r_issued;
  assign err        = |w_slot_err;

endmodule

// File: tb/tb_pipeline_sched.sv
// tb/tb_pipeline_sched.sv - self-checking bench for pipeline_sched with N_CORE=2 and N_CORE=4 instances
module tb_pipeline_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, init2, init4, ar, wr;
  logic [15:0] nt;
  logic [1:0]  ce2, ce2_r, force2, sc2, cb2;
  logic [3:0]  ce4, ce4_r, sc4, cb4;
  logic        sl2, bz2, dn2, er2, sl4, bz4, dn4, er4;
  logic [15:0] ic2, ic4;

  assign ce2 = ce2_r | force2;
  assign ce4 = ce4_r;

  pipeline_sched #(.N_CORE(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .en(en), .init_signal(init2), .num_tiles(nt),
    .activate_ready(ar), .weight_ready(wr), .core_end(ce2), .start_core(sc2),
    .start_load(sl2), .core_busy(cb2), .busy(bz2), .done(dn2), .issued_cnt(ic2), .err(er2)
  );

  pipeline_sched #(.N_CORE(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .en(en), .init_signal(init4), .num_tiles(nt),
    .activate_ready(ar), .weight_ready(wr), .core_end(ce4), .start_core(sc4),
    .start_load(sl4), .core_busy(cb4), .busy(bz4), .done(dn4), .issued_cnt(ic4), .err(er4)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int       cyc = 0;
  logic     rdy_seen;
  logic [1:0] ce2_seen;
  logic [3:0] ce4_seen;
  always @(posedge clk) begin
    cyc++;
    rdy_seen = en & ar & wr;
    ce2_seen = ce2;
    ce4_seen = ce4;
  end

  // Model of the 2-core instance: busy/err from issue and completion events, plus a core responder
  logic [1:0] bm2 = '0;
  logic       em2 = 1'b0;
  int  tmr2[2];
  bit  hold2[2];
  int  exp_ptr2 = 0, n_start2 = 0, n_load2 = 0, n_done2 = 0;
  int  last_start2 = 0, init_cyc2 = 0, done_cyc2 = 0, fix_dly2 = 5, idx2 = 0;
  bit  rnd_dly2 = 1'b0;
  bit  busy_seen2 = 1'b0;
  int  q_cyc2[$];
  int  q_vec2[$];

  always @(negedge clk) begin
    if (!rst) begin
      bm2 = '0; em2 = 1'b0; ce2_r = '0; tmr2[0] = 0; tmr2[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        ce2_r[k] = 1'b0;
        if (tmr2[k] > 0 && !hold2[k]) begin
          tmr2[k]--;
          if (tmr2[k] == 0) ce2_r[k] = 1'b1;
        end
      end
      if (sc2 != '0) begin
        idx2 = sc2[1] ? 1 : 0;
        check_eq("sc2_onehot", $countones(sc2), 1);
        check_eq("sc2_round_robin", idx2, exp_ptr2);
        check_eq("sc2_core_was_free", int'(bm2[idx2]), 0);
        check_eq("sc2_ready_at_edge", int'(rdy_seen), 1);
        if (n_start2 > 0) check_eq("sc2_issue_gap", int'(cyc - last_start2 >= 2), 1);
      end
      em2 = em2 | (|(ce2_seen & ~bm2));
      bm2 = bm2 & ~ce2_seen;
      if (sc2 != '0) begin
        bm2[idx2] = 1'b1;
        tmr2[idx2] = (rnd_dly2 ? $urandom_range(2, 9) : fix_dly2) - 1;
        exp_ptr2 = (exp_ptr2 + 1) % 2;
        n_start2++;
        last_start2 = cyc;
        q_cyc2.push_back(cyc - init_cyc2);
        q_vec2.push_back(int'(sc2));
      end
      check_eq("core_busy2", int'(cb2), int'(bm2));
      check_eq("err2", int'(er2), int'(em2));
      if (sl2) n_load2++;
      if (dn2) begin n_done2++; done_cyc2 = cyc; end
      busy_seen2 = busy_seen2 | bz2;
    end
  end

  logic [3:0] bm4 = '0;
  int  tmr4[4];
  bit  hold4[4];
  int  exp_ptr4 = 0, n_start4 = 0, n_done4 = 0, idx4 = 0;
  int  q_vec4[$];

  always @(negedge clk) begin
    if (!rst) begin
      bm4 = '0; ce4_r = '0;
      for (int k = 0; k < 4; k++) tmr4[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        ce4_r[k] = 1'b0;
        if (tmr4[k] > 0 && !hold4[k]) begin
          tmr4[k]--;
          if (tmr4[k] == 0) ce4_r[k] = 1'b1;
        end
      end
      if (sc4 != '0) begin
        for (int k = 0; k < 4; k++) if (sc4[k]) idx4 = k;
        check_eq("sc4_onehot", $countones(sc4), 1);
        check_eq("sc4_round_robin", idx4, exp_ptr4);
        check_eq("sc4_core_was_free", int'(bm4[idx4]), 0);
      end
      bm4 = bm4 & ~ce4_seen;
      if (sc4 != '0) begin
        bm4[idx4] = 1'b1;
        tmr4[idx4] = 3;
        exp_ptr4 = (exp_ptr4 + 1) % 4;
        n_start4++;
        q_vec4.push_back(int'(sc4));
      end
      if (dn4) n_done4++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_job2(input int n);
    n_start2 = 0; n_load2 = 0; n_done2 = 0; exp_ptr2 = 0; busy_seen2 = 1'b0;
    q_cyc2.delete(); q_vec2.delete();
    nt = 16'(n);
    init_cyc2 = cyc + 1;
    init2 = 1'b1;
    step(1);
    init2 = 1'b0;
    nt = 16'hffff;
  endtask

  task automatic wait_done2(input string tag, input int budget, input bit rnd);
    int c = 0;
    while (dn2 !== 1'b1 && c < budget) begin
      if (rnd) begin
        en = ($urandom_range(0, 3) != 0);
        ar = ($urandom_range(0, 3) != 0);
        wr = ($urandom_range(0, 3) != 0);
        init2 = bz2 && ($urandom_range(0, 15) == 0);
        nt = 16'($urandom);
      end
      step(1);
      c++;
    end
    init2 = 1'b0; en = 1'b1; ar = 1'b1; wr = 1'b1;
    check_eq(tag, int'(dn2 === 1'b1), 1);
    step(3);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int exp_vec[3] = '{1, 2, 1};
  int exp_cyc[3] = '{1, 3, 7};
  int d0, c, ntr;

  initial begin
    rst = 1'b0; en = 1'b0; init2 = 1'b0; init4 = 1'b0; ar = 1'b0; wr = 1'b0;
    nt = '0; force2 = '0;
    hold2[0] = 1'b0; hold2[1] = 1'b0;
    for (int k = 0; k < 4; k++) hold4[k] = 1'b0;
    step(2);
    check_eq("rst_start_core", int'(sc2), 0);
    check_eq("rst_start_load", int'(sl2), 0);
    check_eq("rst_core_busy", int'(cb2), 0);
    check_eq("rst_busy", int'(bz2), 0);
    check_eq("rst_done", int'(dn2), 0);
    check_eq("rst_issued_cnt", int'(ic2), 0);
    check_eq("rst_err", int'(er2), 0);
    check_eq("rst_busy4", int'(bz4), 0);
    rst = 1'b1;
    en = 1'b1; ar = 1'b1; wr = 1'b1;
    step(2);

    // Three tiles on two cores, completion five cycles after each start
    fix_dly2 = 5;
    start_job2(3);
    wait_done2("j3_done_seen", 100, 1'b0);
    check_eq("j3_starts", n_start2, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("j3_core_order", qget(q_vec2, i), exp_vec[i]);
      check_eq("j3_issue_cycle", qget(q_cyc2, i), exp_cyc[i]);
    end
    check_eq("j3_loads", n_load2, 3);
    check_eq("j3_done_count", n_done2, 1);
    check_eq("j3_done_cycle", done_cyc2 - init_cyc2, 13);
    check_eq("j3_issued_cnt", int'(ic2), 3);
    check_eq("j3_busy_after", int'(bz2), 0);

    // Zero-tile job
    start_job2(0);
    check_eq("j0_done_next", int'(dn2), 1);
    check_eq("j0_busy", int'(bz2), 0);
    step(1);
    check_eq("j0_done_single", int'(dn2), 0);
    step(2);
    check_eq("j0_starts", n_start2, 0);
    check_eq("j0_loads", n_load2, 0);
    check_eq("j0_busy_seen", int'(busy_seen2), 0);
    check_eq("j0_done_count", n_done2, 1);

    // weight_ready withdrawn for ten cycles after the first issue
    fix_dly2 = 3;
    start_job2(4);
    c = 0;
    while (sc2 == '0 && c < 10) begin step(1); c++; end
    check_eq("wr_first_issue", int'(sc2), 1);
    wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_eq("wr_low_no_issue", int'(sc2), 0);
    end
    wr = 1'b1;
    step(1);
    check_eq("wr_resume_issue", int'(sc2), 2);
    wait_done2("wr_done_seen", 100, 1'b0);
    check_eq("wr_starts", n_start2, 4);
    check_eq("wr_loads", n_load2, 4);
    check_eq("wr_issued_cnt", int'(ic2), 4);

    // Completion on an idle core
    force2 = 2'b10;
    step(1);
    force2 = 2'b00;
    check_eq("spurious_err_set", int'(er2), 1);
    check_eq("spurious_busy", int'(cb2), 0);
    step(4);
    check_eq("spurious_err_sticky", int'(er2), 1);

    // Reset while core 0 is held busy
    hold2[0] = 1'b1;
    start_job2(3);
    c = 0;
    while (sc2 == '0 && c < 10) begin step(1); c++; end
    step(2);
    check_eq("mid_core0_busy", int'(cb2[0]), 1);
    d0 = n_done2;
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_start_core", int'(sc2), 0);
    check_eq("mid_rst_start_load", int'(sl2), 0);
    check_eq("mid_rst_core_busy", int'(cb2), 0);
    check_eq("mid_rst_busy", int'(bz2), 0);
    check_eq("mid_rst_done", int'(dn2), 0);
    check_eq("mid_rst_issued_cnt", int'(ic2), 0);
    check_eq("mid_rst_err", int'(er2), 0);
    hold2[0] = 1'b0;
    step(3);
    rst = 1'b1;
    step(3);
    check_eq("mid_rst_no_done", n_done2 - d0, 0);
    fix_dly2 = 5;
    start_job2(2);
    wait_done2("post_rst_done_seen", 100, 1'b0);
    check_eq("post_rst_first_core", qget(q_vec2, 0), 1);
    check_eq("post_rst_starts", n_start2, 2);
    check_eq("post_rst_issued_cnt", int'(ic2), 2);

    // Randomized jobs with random readies, enables, completion delays and ignored inits
    rnd_dly2 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      ntr = $urandom_range(1, 12);
      start_job2(ntr);
      wait_done2("rnd_done_seen", 800, 1'b1);
      check_eq("rnd_starts", n_start2, ntr);
      check_eq("rnd_loads", n_load2, ntr);
      check_eq("rnd_done_count", n_done2, 1);
      check_eq("rnd_issued_cnt", int'(ic2), ntr);
      check_eq("rnd_busy_after", int'(bz2), 0);
    end

    // Four cores, six tiles, core 0 held busy after its first tile
    hold4[0] = 1'b1;
    n_start4 = 0; n_done4 = 0; exp_ptr4 = 0; q_vec4.delete();
    nt = 16'd6;
    init4 = 1'b1;
    step(1);
    init4 = 1'b0;
    step(20);
    check_eq("c4_stall_starts", n_start4, 4);
    check_eq("c4_core0_busy", int'(cb4[0]), 1);
    for (int i = 0; i < 4; i++) check_eq("c4_first_round", qget(q_vec4, i), 1 << i);
    hold4[0] = 1'b0;
    c = 0;
    while (dn4 !== 1'b1 && c < 100) begin step(1); c++; end
    check_eq("c4_done_seen", int'(dn4 === 1'b1), 1);
    step(2);
    check_eq("c4_resume_core0", qget(q_vec4, 4), 1);
    check_eq("c4_then_core1", qget(q_vec4, 5), 2);
    check_eq("c4_starts", n_start4, 6);
    check_eq("c4_issued_cnt", int'(ic4), 6);
    check_eq("c4_done_count", n_done4, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_sched.md
PIPELINE_SCHED -- requirements
Module: pipeline_sched

Interface
REQ-001 Parameter N_CORE, default 2, number of compute cores scheduled (1..8).
REQ-002 Parameter CNT_W, default 16, width of the tile counters.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  from controller; 0 pauses new issues, core tracking continues.
REQ-006 init_signal  input  1  from controller; one-cycle job start request, honoured only in IDLE.
REQ-007 num_tiles  input  CNT_W  tiles in the job; sampled on the accepted init_signal.
REQ-008 activate_ready  input  1  activation buffer loaded (level).
REQ-009 weight_ready  input  1  buffer_ready of load_weight_ctrl (level).
REQ-010 core_end  input  N_CORE  per-core one-cycle completion pulse from the accumulators.
REQ-011 start_core  output  N_CORE  one-hot, one-cycle start pulse per core.
REQ-012 start_load  output  1  one-cycle load request to load_activate.
REQ-013 core_busy  output  N_CORE  per-core busy flag.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle job-complete pulse.
REQ-016 issued_cnt  output  CNT_W  tiles issued in the current job.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 FSM states: IDLE, RUN, HOLD, DRAIN; all outputs registered.
REQ-019 IDLE: init_signal=1 with num_tiles>0 -> latch num_tiles, clear issued_cnt and pointer, pulse start_load next cycle, enter RUN.
REQ-020 IDLE: init_signal=1 with num_tiles=0 -> no start_load, done pulses next cycle, remain IDLE.
REQ-021 RUN issue condition at an edge: en & activate_ready & weight_ready & ~core_busy[ptr] & issued_cnt<latched num_tiles.
REQ-022 On issue: next cycle start_core[ptr]=1, core_busy[ptr]=1, issued_cnt+1, ptr advances modulo N_CORE, FSM enters HOLD.
REQ-023 Core order strictly round-robin from core 0; never skip a busy core, wait for it.
REQ-024 start_load pulses together with start_core unless that issue is the last tile (no prefetch beyond the job).
REQ-025 HOLD lasts exactly one cycle, ignores ready inputs, then RUN (or DRAIN if issued_cnt equals num_tiles); max issue rate one per two cycles.
REQ-026 core_end[k] with core_busy[k]=1 -> core_busy[k]=0 next cycle; core freed this way is eligible at the following edge.
REQ-027 core_end[k] with core_busy[k]=0 -> ignored for tracking, err set to 1 until reset.
REQ-028 core_end on one core and issue on another in the same cycle: both take effect.
REQ-029 DRAIN: when all core_busy are 0, pulse done next cycle and return to IDLE.
REQ-030 init_signal outside IDLE ignored; num_tiles changes after acceptance ignored.
REQ-031 en=0 in RUN: no issues, state held; core_end still processed.

Reset
REQ-032 rst=0 asynchronously forces IDLE, ptr=0, issued_cnt=0, latched count=0, start_core=0, start_load=0, core_busy=0, busy=0, done=0, err=0.
REQ-033 Reset mid-job abandons the job; no done pulse is generated for it.

Structure
REQ-034 FSM state encodings and the default N_CORE/CNT_W constants reside in shared package pipeline_sched_pkg.
REQ-035 Per-core busy/err tracking is one sub-module core_slot, instantiated N_CORE times by generate.

Verification
REQ-036 N_CORE=2, num_tiles=3, readies high, core_end 5 cycles after each start -> start_core 01,10,01; start_load 3 pulses (init + 2); done once; issued_cnt=3.
REQ-037 num_tiles=0 init -> done one cycle later, no start_core, no start_load, busy stays 0.
REQ-038 weight_ready low 10 cycles in RUN -> no start_core for those cycles; issue 1 cycle after it rises.
REQ-039 core_end[1] with core 1 idle -> err=1 and stays 1; core_busy unaffected.
REQ-040 rst asserted while core 0 busy in RUN -> all outputs 0 immediately, no done; new init then runs normally from core 0.
REQ-041 N_CORE=4, num_tiles=6, core 0 held busy -> issues stall at core 0 without skipping to core 1; resume on core_end[0].
